// File: rtl/wakeupspi_cmd_sched.sv
// Wake-up SPI command scheduler: replays a programmed list of SPI
// command words for N passes, with stall timeout and abort.

module wakeupspi_cmd_sched #(
    parameter int DEPTH = 8,
    parameter int TMO_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     prog_we_i,
    input  logic [$clog2(DEPTH)-1:0] prog_addr_i,
    input  logic [31:0]              prog_data_i,
    input  logic [$clog2(DEPTH):0]   cfg_len_i,
    input  logic [7:0]               cfg_repeat_i,
    input  logic [TMO_W-1:0]         cfg_timeout_i,
    input  logic                     trig_i,
    input  logic                     abort_i,
    output logic [31:0]              cmd_o,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    input  logic                     eot_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_slot [DEPTH];
    logic [AW-1:0]    r_idx;
    logic [AW:0]      r_len;
    logic [7:0]       r_rep;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] r_cnt;
    logic             r_done;
    logic             r_err;

    logic             w_start;
    logic             w_hs;
    logic             w_last;
    logic             w_stall;
    logic [TMO_W-1:0] w_cnt_inc;
    logic             w_tmo_hit;
    logic             w_done_set;
    logic             w_err_set;

    assign w_start   = (r_state == S_IDLE) && trig_i && (cfg_len_i != '0);
    assign w_hs      = (r_state == S_ISSUE) && cmd_ready_i;
    assign w_last    = ({1'b0, r_idx} == (r_len - 1'b1));
    assign w_stall   = ((r_state == S_ISSUE) && !cmd_ready_i)
                    || ((r_state == S_WAIT) && !eot_i);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    // Compare the post-increment value so the limit fires on the Nth stall cycle
    assign w_tmo_hit = w_stall && (r_tmo != '0) && (w_cnt_inc == r_tmo);

    assign w_done_set = !abort_i && (r_state == S_WAIT) && eot_i
                     && (r_rep == '0);
    assign w_err_set  = !abort_i && w_tmo_hit;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) w_state_nxt = S_ISSUE;
                end
                S_ISSUE: begin
                    if (w_tmo_hit)
                        w_state_nxt = S_IDLE;
                    else if (w_hs && w_last)
                        w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (w_tmo_hit)
                        w_state_nxt = S_IDLE;
                    else if (eot_i)
                        w_state_nxt = (r_rep == '0) ? S_IDLE : S_ISSUE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_valid_o = (r_state == S_ISSUE);
        cmd_o       = (r_state == S_ISSUE) ? r_slot[r_idx] : '0;
        busy_o      = (r_state != S_IDLE);
        done_o      = r_done;
        err_o       = r_err;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
        end else if (prog_we_i && (r_state == S_IDLE)) begin
            r_slot[prog_addr_i] <= prog_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_idx  <= '0;
            r_len  <= '0;
            r_rep  <= '0;
            r_tmo  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_done_set;
            r_err  <= w_err_set;
            if (w_start && !abort_i) begin
                r_len <= cfg_len_i;
                r_rep <= cfg_repeat_i;
                r_tmo <= cfg_timeout_i;
            end else if ((r_state == S_WAIT) && (w_state_nxt == S_ISSUE)) begin
                r_rep <= r_rep - 1'b1;
            end
            // Every state change restarts the pass pointer and stall timer
            if (w_state_nxt != r_state)
                r_idx <= '0;
            else if (w_hs && !w_last)
                r_idx <= r_idx + 1'b1;
            if ((w_state_nxt != r_state) || w_hs)
                r_cnt <= '0;
            else if (w_stall)
                r_cnt <= w_cnt_inc;
        end
    end

endmodule

// File: tb/tb_wakeupspi_cmd_sched.sv
// Bench for wakeupspi_cmd_sched: directed sequences, scenario table,
// and randomized runs against a pass/queue reference model.

module tb_wakeupspi_cmd_sched;

    localparam int DEPTH = 8;
    localparam int TMO_W = 16;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             prog_we;
    logic [AW-1:0]    prog_addr;
    logic [31:0]      prog_data;
    logic [AW:0]      cfg_len;
    logic [7:0]       cfg_rep;
    logic [TMO_W-1:0] cfg_tmo;
    logic             trig;
    logic             abort;
    logic [31:0]      cmd;
    logic             valid;
    logic             ready;
    logic             eot;
    logic             busy;
    logic             done;
    logic             err;

    wakeupspi_cmd_sched #(.DEPTH(DEPTH), .TMO_W(TMO_W)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .prog_we_i    (prog_we),
        .prog_addr_i  (prog_addr),
        .prog_data_i  (prog_data),
        .cfg_len_i    (cfg_len),
        .cfg_repeat_i (cfg_rep),
        .cfg_timeout_i(cfg_tmo),
        .trig_i       (trig),
        .abort_i      (abort),
        .cmd_o        (cmd),
        .cmd_valid_o  (valid),
        .cmd_ready_i  (ready),
        .eot_i        (eot),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int len;
        int rep;
        int tmo;
        int stall;
        bit give_eot;
        int exp_hs;
        int exp_done;
        int exp_err;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic prog(input int a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = d;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic trigger(input int len, input int rep, input int tmo);
        cfg_len = (AW+1)'(len);
        cfg_rep = 8'(rep);
        cfg_tmo = TMO_W'(tmo);
        trig    = 1'b1;
        @(negedge clk);
        trig    = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int hs, dn, er, stall, wcnt;
        bit waiting;
        hs = 0; dn = 0; er = 0; stall = 0; wcnt = 0; waiting = 0;
        ready = 1'b0;
        trigger(v.len, v.rep, v.tmo);
        for (int c = 0; c < 400; c++) begin
            if (done) dn++;
            if (err) er++;
            if (done || err || !busy) break;
            ready = (stall >= v.stall);
            eot   = 1'b0;
            if (waiting) begin
                if (v.give_eot && wcnt == 2) begin
                    eot = 1'b1;
                    waiting = 0;
                end
                wcnt++;
            end
            if (valid && ready) begin
                hs++;
                stall = 0;
                if (hs % v.len == 0) begin
                    waiting = 1;
                    wcnt = 0;
                end
            end else if (valid) begin
                stall++;
            end
            @(negedge clk);
        end
        eot = 1'b0;
        ready = 1'b0;
        chk("tbl handshakes", hs, v.exp_hs);
        chk("tbl done", dn, v.exp_done);
        chk("tbl err", er, v.exp_err);
        chk("tbl idle at end", busy, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] mslot [DEPTH];
        logic [31:0] q [$];
        int len, rep, left, in_pass, phase;
        bit exp_done;
        int cyc;

        prog_we = 0; prog_addr = '0; prog_data = '0;
        cfg_len = '0; cfg_rep = '0; cfg_tmo = '0;
        trig = 0; abort = 0; ready = 0; eot = 0;

        repeat (3) @(negedge clk);
        chk("rst valid", valid, 0);
        chk("rst cmd", cmd, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Basic three-word pass at full rate
        prog(0, 32'h1000_0001);
        prog(1, 32'h2000_0002);
        prog(2, 32'h3000_0003);
        ready = 1'b1;
        trigger(3, 0, 0);
        chk("A valid at N+1", valid, 1);
        chk("A word0", cmd, 32'h1000_0001);
        @(negedge clk);
        chk("A word1", cmd, 32'h2000_0002);
        @(negedge clk);
        chk("A word2", cmd, 32'h3000_0003);
        @(negedge clk);
        chk("A wait valid", valid, 0);
        chk("A wait busy", busy, 1);
        ready = 1'b0;
        eot = 1'b1;
        @(negedge clk);
        eot = 1'b0;
        chk("A done", done, 1);
        chk("A busy after", busy, 0);
        @(negedge clk);
        chk("A done pulse", done, 0);

        // Back-pressure on word 1
        ready = 1'b1;
        trigger(3, 0, 0);
        chk("B word0", cmd, 32'h1000_0001);
        @(negedge clk);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("B hold valid", valid, 1);
            chk("B hold word", cmd, 32'h2000_0002);
            @(negedge clk);
        end
        ready = 1'b1;
        chk("B word1", cmd, 32'h2000_0002);
        @(negedge clk);
        chk("B word2", cmd, 32'h3000_0003);
        @(negedge clk);
        chk("B wait", valid, 0);
        ready = 1'b0;
        eot = 1'b1;
        @(negedge clk);
        eot = 1'b0;
        chk("B done", done, 1);
        @(negedge clk);

        // Timeout of 10 with the core never ready
        ready = 1'b0;
        trigger(3, 0, 10);
        cyc = 0;
        while (valid && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        chk("C stall cycles", cyc, 10);
        chk("C err", err, 1);
        chk("C valid dropped", valid, 0);
        chk("C no done", done, 0);
        @(negedge clk);
        chk("C err pulse", err, 0);

        // Abort with final eot, and a write while busy
        ready = 1'b1;
        trigger(3, 0, 0);
        repeat (3) @(negedge clk);
        chk("D in wait", busy, 1);
        ready = 1'b0;
        prog_we = 1'b1;
        prog_addr = 3'd1;
        prog_data = 32'hDEAD_BEEF;
        eot = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; eot = 1'b0; abort = 1'b0;
        chk("D abort idle", busy, 0);
        chk("D abort no done", done, 0);
        chk("D abort no err", err, 0);
        @(negedge clk);
        chk("D no late done", done, 0);
        abort = 1'b1;
        trigger(3, 0, 0);
        abort = 1'b0;
        chk("D abort beats trig", busy, 0);
        ready = 1'b1;
        trigger(3, 0, 0);
        chk("D rerun word0", cmd, 32'h1000_0001);
        @(negedge clk);
        chk("D slot1 kept", cmd, 32'h2000_0002);
        @(negedge clk);
        @(negedge clk);
        ready = 1'b0;
        eot = 1'b1;
        @(negedge clk);
        eot = 1'b0;
        chk("D rerun done", done, 1);
        @(negedge clk);

        // Asynchronous reset while waiting for eot
        ready = 1'b1;
        trigger(2, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("E in wait", busy, 1);
        ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("E rst busy", busy, 0);
        chk("E rst valid", valid, 0);
        chk("E rst cmd", cmd, 0);
        chk("E rst done", done, 0);
        chk("E rst err", err, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("E no done after rst", done, 0);
        trigger(0, 0, 0);
        chk("E len0 ignored", busy, 0);
        @(negedge clk);
        chk("E len0 still idle", valid, 0);
        trigger(1, 0, 0);
        chk("E slot cleared valid", valid, 1);
        chk("E slot cleared", cmd, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("E abort issue", busy, 0);

        tbl[0] = '{3, 0, 0, 0, 1, 3, 1, 0};
        tbl[1] = '{2, 2, 0, 0, 1, 6, 1, 0};
        tbl[2] = '{1, 0, 0, 2, 1, 1, 1, 0};
        tbl[3] = '{8, 1, 0, 1, 1, 16, 1, 0};
        tbl[4] = '{3, 0, 4, 10, 1, 0, 0, 1};
        tbl[5] = '{2, 0, 5, 3, 1, 2, 1, 0};
        tbl[6] = '{2, 0, 3, 0, 0, 2, 0, 1};
        tbl[7] = '{0, 0, 0, 0, 1, 0, 0, 0};
        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Random programs, repeat counts, ready and eot traffic
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mslot[i] = $urandom;
                prog(i, mslot[i]);
            end
            len = $urandom_range(1, DEPTH);
            rep = $urandom_range(0, 3);
            q.delete();
            for (int p = 0; p <= rep; p++)
                for (int i = 0; i < len; i++) q.push_back(mslot[i]);
            ready = 1'b0;
            trigger(len, rep, 0);
            phase = 1;
            in_pass = len;
            left = rep;
            exp_done = 0;
            for (int c = 0; c < 3000; c++) begin
                chk("rnd valid", valid, (phase == 1));
                chk("rnd busy", busy, (phase != 0));
                chk("rnd done", done, exp_done);
                if (phase == 0) break;
                exp_done = 0;
                ready = 1'($urandom % 2);
                eot = ($urandom % 3 == 0);
                if (phase == 1 && ready) begin
                    chk("rnd word", cmd, q.pop_front());
                    in_pass--;
                    if (in_pass == 0) phase = 2;
                end else if (phase == 2 && eot) begin
                    if (left == 0) begin
                        phase = 0;
                        exp_done = 1;
                    end else begin
                        left--;
                        in_pass = len;
                        phase = 1;
                    end
                end
                @(negedge clk);
            end
            ready = 1'b0;
            eot = 1'b0;
            chk("rnd drained", q.size(), 0);
            chk("rnd finished", phase, 0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
